// File: rtl/tmds_word_serializer_pkg.sv
// Shared constants, bit-counter sizing helper and FSM state type for the TMDS word serializer.
// Import with: import tmds_ser_pkg::*;
package tmds_ser_pkg;

  // The four TMDS control-period words, indexed by {C1,C0}
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  // The fixed 10:1 command serializer idled on the C1=C0=0 control word
  localparam logic [9:0] CMD_IDLE_WORD = TMDS_CTRL_00;

  localparam int MAX_WIDTH    = 16;
  localparam int MAX_CHANNELS = 8;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

endpackage

// File: rtl/tmds_word_serializer_if.sv
// Word-load handshake and serial-output bundle of the TMDS word serializer.
// master = upstream encoder / observer side, slave = serializer side.
interface tmds_word_serializer_if #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 10
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS-1:0]       ser_out;
  logic                      word_start;
  logic                      underflow;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, word_start, underflow
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, word_start, underflow
  );
endinterface

// File: rtl/tmds_ser_lane.sv
// One lane: WIDTH-bit load/shift register, output bit taken straight from a flop.
// Loads i_word when i_load is high, otherwise shifts one position toward the output bit.
module tmds_ser_lane #(
  parameter int               WIDTH      = 10,
  parameter bit               LSB_FIRST  = 1'b1,
  parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
  input  logic             clk_px,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_sreg;

  always_ff @(posedge clk_px) begin
    if (!reset_n) begin
      r_sreg <= RESET_WORD;
    end else if (i_load) begin
      r_sreg <= i_word;
    end else if (LSB_FIRST) begin
      r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
    end else begin
      r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign o_bit = LSB_FIRST ? r_sreg[0] : r_sreg[WIDTH-1];

endmodule

// File: rtl/tmds_word_serializer.sv
// CHANNELS x WIDTH-bit word serializer with one-entry holding register; words reach ser_out at the boundary after acceptance.
// in_ready drops while hold is full except at a word boundary; optional underflow counter under TMDS_SER_UNDERFLOW_CNT_EN.
module tmds_word_serializer
  import tmds_ser_pkg::*;
#(
  parameter int               CHANNELS  = 3,
  parameter int               WIDTH     = 10,
  parameter bit               LSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(TMDS_CTRL_00)
) (
  input  logic                  clk_px,
  input  logic                  reset_n,
  tmds_word_serializer_if.slave bus
`ifdef TMDS_SER_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]           underflow_cnt
`endif
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [CW-1:0]             r_bit_cnt;
  logic [CHANNELS*WIDTH-1:0] r_hold;
  logic                      r_hold_full;
  logic                      r_word_start;
  logic                      r_underflow;
  logic                      r_rst_n_q;
  state_t                    r_state;

  state_t                    w_state_nxt;
  logic                      w_boundary;
  logic                      w_in_ready;
  logic                      w_xfer;
  logic                      w_load_hold;
  logic                      w_underflow_nxt;
  logic [CHANNELS-1:0]       w_ser_out;

  assign w_boundary = (r_bit_cnt == LAST);
  assign w_in_ready = r_rst_n_q && (!r_hold_full || w_boundary);
  assign w_xfer     = bus.in_valid && w_in_ready;

  // Unreset on purpose: keeps in_ready low for the first cycle after reset release
  always_ff @(posedge clk_px) begin
    r_rst_n_q <= reset_n;
  end

  always_ff @(posedge clk_px) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_load_hold     = 1'b0;
    w_underflow_nxt = 1'b0;
    if (w_boundary) begin
      if (r_hold_full) begin
        w_load_hold = 1'b1;
        w_state_nxt = ST_STREAM;
      end else if (r_state == ST_STREAM) begin
        w_underflow_nxt = 1'b1;
      end
    end
  end

  // A same-cycle transfer refills hold after its old word drains, so hold_full stays set
  always_ff @(posedge clk_px) begin
    if (!reset_n) begin
      r_bit_cnt    <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_word_start <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_bit_cnt    <= w_boundary ? '0 : r_bit_cnt + CW'(1);
      r_word_start <= w_boundary;
      r_underflow  <= w_underflow_nxt;
      if (w_xfer) begin
        r_hold      <= bus.in_data;
        r_hold_full <= 1'b1;
      end else if (w_load_hold) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    tmds_ser_lane #(
      .WIDTH      (WIDTH),
      .LSB_FIRST  (LSB_FIRST),
      .RESET_WORD (IDLE_WORD)
    ) u_lane (
      .clk_px (clk_px),
      .reset_n(reset_n),
      .i_load (w_boundary),
      .i_word (w_load_hold ? r_hold[c*WIDTH +: WIDTH] : IDLE_WORD),
      .o_bit  (w_ser_out[c])
    );
  end

  assign bus.ser_out    = w_ser_out;
  assign bus.in_ready   = w_in_ready;
  assign bus.word_start = r_word_start;
  assign bus.underflow  = r_underflow;

`ifdef TMDS_SER_UNDERFLOW_CNT_EN
  logic [15:0] r_underflow_cnt;

  always_ff @(posedge clk_px) begin
    if (!reset_n) begin
      r_underflow_cnt <= '0;
    end else if (w_underflow_nxt && (r_underflow_cnt != 16'hFFFF)) begin
      r_underflow_cnt <= r_underflow_cnt + 16'd1;
    end
  end

  assign underflow_cnt = r_underflow_cnt;
`endif

endmodule

// File: tb/tb_tmds_word_serializer.sv
// Randomised bench: two serializer builds (3x10 LSB-first default idle, 2x4 MSB-first) checked each cycle
// against a word-level model that tracks the current word, a pending-word queue and the bit position.
module tb_tmds_word_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tmds_word_serializer_if #(.CHANNELS(3), .WIDTH(10)) bus0();
  tmds_word_serializer_if #(.CHANNELS(2), .WIDTH(4))  bus1();

`ifdef TMDS_SER_UNDERFLOW_CNT_EN
  logic [15:0] ucnt0, ucnt1;
`endif

  tmds_word_serializer #(.CHANNELS(3), .WIDTH(10), .LSB_FIRST(1'b1)) u_dut0 (
    .clk_px (clk),
    .reset_n(rst_n),
    .bus    (bus0.slave)
`ifdef TMDS_SER_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt(ucnt0)
`endif
  );

  tmds_word_serializer #(.CHANNELS(2), .WIDTH(4), .LSB_FIRST(1'b0), .IDLE_WORD(4'b0110)) u_dut1 (
    .clk_px (clk),
    .reset_n(rst_n),
    .bus    (bus1.slave)
`ifdef TMDS_SER_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt(ucnt1)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;  // cycles since reset release; t % W is the send-order bit index

  int          m_w   [2] = '{10, 4};
  int          m_ch  [2] = '{3, 2};
  bit          m_lsb [2] = '{1'b1, 1'b0};
  logic [31:0] m_idle[2] = '{32'h354, 32'h6};
  logic [31:0] m_cur [2];
  logic [31:0] m_q0[$];
  logic [31:0] m_q1[$];
  bit          m_stream[2];
  bit          m_rstq  [2];
  bit          m_uf    [2];
  int          m_ufcnt [2];

  bit          pend   [2];
  bit          drv_vld[2];
  logic [31:0] drv_dat[2];
  int          seq = 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, got, exp, t);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? m_q0.size() : m_q1.size();
  endfunction

  function automatic logic [31:0] idle_vec(input int d);
    logic [31:0] v = '0;
    for (int c = 0; c < m_ch[d]; c++) v |= m_idle[d] << (c * m_w[d]);
    return v;
  endfunction

  function automatic logic [31:0] exp_ser(input int d);
    logic [31:0] r = '0;
    int p = t % m_w[d];
    for (int c = 0; c < m_ch[d]; c++)
      r[c] = m_cur[d][c*m_w[d] + (m_lsb[d] ? p : (m_w[d] - 1 - p))];
    return r;
  endfunction

  function automatic bit exp_rdy(input int d);
    return m_rstq[d] && (qsize(d) == 0 || (t % m_w[d]) == m_w[d] - 1);
  endfunction

  task automatic model_reset(input int d);
    m_cur[d]    = idle_vec(d);
    m_stream[d] = 1'b0;
    m_rstq[d]   = 1'b0;
    m_uf[d]     = 1'b0;
    m_ufcnt[d]  = 0;
    if (d == 0) m_q0.delete(); else m_q1.delete();
  endtask

  task automatic model_step(input int d, input bit rstv);
    bit rdy = exp_rdy(d);
    if (!rstv) begin
      model_reset(d);
      return;
    end
    m_uf[d] = 1'b0;
    if ((t % m_w[d]) == m_w[d] - 1) begin
      if (qsize(d) > 0) begin
        m_cur[d]    = (d == 0) ? m_q0.pop_front() : m_q1.pop_front();
        m_stream[d] = 1'b1;
      end else begin
        m_cur[d] = idle_vec(d);
        if (m_stream[d]) begin
          m_uf[d] = 1'b1;
          if (m_ufcnt[d] < 65535) m_ufcnt[d]++;
        end
      end
    end
    if (drv_vld[d] && rdy) begin
      if (d == 0) m_q0.push_back(drv_dat[d]); else m_q1.push_back(drv_dat[d]);
      pend[d]    = 1'b0;
      drv_vld[d] = 1'b0;
    end
    m_rstq[d] = 1'b1;
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [31:0] ser = (d == 0) ? 32'(bus0.ser_out)    : 32'(bus1.ser_out);
      logic [31:0] ws  = (d == 0) ? 32'(bus0.word_start) : 32'(bus1.word_start);
      logic [31:0] uf  = (d == 0) ? 32'(bus0.underflow)  : 32'(bus1.underflow);
      logic [31:0] rdy = (d == 0) ? 32'(bus0.in_ready)   : 32'(bus1.in_ready);
      check_eq($sformatf("d%0d.ser_out", d), ser, exp_ser(d));
      check_eq($sformatf("d%0d.word_start", d), ws, 32'(t >= m_w[d] && (t % m_w[d]) == 0));
      check_eq($sformatf("d%0d.underflow", d), uf, 32'(m_uf[d]));
      check_eq($sformatf("d%0d.in_ready", d), rdy, 32'(exp_rdy(d)));
`ifdef TMDS_SER_UNDERFLOW_CNT_EN
      check_eq($sformatf("d%0d.underflow_cnt", d), (d == 0) ? 32'(ucnt0) : 32'(ucnt1), 32'(m_ufcnt[d]));
`endif
    end
  endtask

  // Called at a falling edge: check this cycle, drive inputs, advance the model past the next rising edge
  task automatic tick(input bit rstv);
    check_all();
    rst_n         = rstv;
    bus0.in_valid = drv_vld[0];
    bus0.in_data  = drv_dat[0][29:0];
    bus1.in_valid = drv_vld[1];
    bus1.in_data  = drv_dat[1][7:0];
    model_step(0, rstv);
    model_step(1, rstv);
    t = rstv ? t + 1 : 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // pct: chance of offering a new word when none is pending; seqmode: incrementing words on every lane
  task automatic run(input int ncyc, input int pct, input bit seqmode);
    for (int i = 0; i < ncyc; i++) begin
      for (int d = 0; d < 2; d++) begin
        if (!pend[d] && $urandom_range(0, 99) < pct) begin
          if (seqmode) drv_dat[d] = (d == 0) ? {2'b0, 10'(seq), 10'(seq), 10'(seq)} : {24'b0, 4'(seq), 4'(seq)};
          else         drv_dat[d] = $urandom & ((d == 0) ? 32'h3FFF_FFFF : 32'h0000_00FF);
          pend[d] = 1'b1;
          if (d == 1) seq++;
        end
        drv_vld[d] = pend[d];
      end
      tick(1'b1);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus0.in_valid = 1'b0;
    bus0.in_data  = '0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;
    for (int d = 0; d < 2; d++) begin
      pend[d]    = 1'b0;
      drv_vld[d] = 1'b0;
      drv_dat[d] = '0;
      model_reset(d);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    tick(1'b0);
    tick(1'b0);

    // Idle after reset: idle words only, no underflow
    run(40, 0, 1'b0);

    // Single word accepted 3 cycles after reset release
    tick(1'b0);
    run(3, 0, 1'b0);
    pend[0] = 1'b1; drv_dat[0] = 32'h3A5;
    pend[1] = 1'b1; drv_dat[1] = 32'h08;
    run(30, 0, 1'b0);

    // Back-to-back incrementing words
    seq = 1;
    run(170, 100, 1'b1);

    // One-cycle reset mid-word while hold is full, then drain to idle
    while ((t % 10) != 5) run(1, 100, 1'b1);
    tick(1'b0);
    run(40, 0, 1'b0);

    // Random traffic
    run(300, 40, 1'b0);
    run(200, 90, 1'b0);
    run(60, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
